// File: rtl/shift_reg_seq_ctrl_pkg.sv
// Shared types, CTRL codes and parameter legality checks for the shift register sequencer.
package shift_reg_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHL  = 2'b01;
    localparam logic [1:0] CTRL_LOAD = 2'b10;
    localparam logic [1:0] CTRL_SHR  = 2'b11;

    localparam int REG_WIDTH = 8;
    localparam int DIV_MAX   = 255;

    function automatic bit width_legal(input int width);
        return width == REG_WIDTH;
    endfunction

    function automatic bit div_legal(input int div, input int cnt_w);
        return (div >= 1) && (div <= DIV_MAX) && ((cnt_w >= 31) || (div <= (1 << cnt_w)));
    endfunction

endpackage

// File: rtl/shift_reg_seq_ctrl_if.sv
// Request handshake between a word producer and the shift register sequencer.
interface shift_reg_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] data_in;
    logic             dir_in;
    logic             fill_in;

    modport master (
        output start_valid, data_in, dir_in, fill_in,
        input  start_ready
    );

    modport slave (
        input  start_valid, data_in, dir_in, fill_in,
        output start_ready
    );
endinterface

// File: rtl/shift_reg_seq_ctrl_tick.sv
// Shift-step divider: counts 0..DIV-1 while running and flags the last count as a one-cycle tick.
module shift_tick_gen
    import shift_reg_seq_ctrl_pkg::*;
#(
    parameter int DIV   = 1,
    parameter int CNT_W = 8
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer that parallel-loads one word into an 8-bit universal shift register and shifts it out.
// Build option SEQ_ROTATE_EN: feed the register's own serial end back on S_IN so the word rotates.
//
// state | meaning
// IDLE  | waiting for a request, start_ready high
// LOAD  | one cycle of CTRL=10 with the latched word on D
// SHIFT | WIDTH enabled shift steps, one every DIV cycles
// DONE  | one-cycle done pulse, register held
module shift_reg_seq_ctrl
    import shift_reg_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int CNT_W = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    shift_reg_seq_ctrl_if.slave req,
    input  logic             abort,
`ifdef SEQ_ROTATE_EN
    input  logic [WIDTH-1:0] reg_q,
`endif
    output logic [1:0]       ctrl_out,
    output logic             enable_out,
    output logic             s_in_out,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);

    localparam int SCNT_W = $clog2(WIDTH + 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("shift_reg_seq_ctrl: WIDTH must equal the register width");
    end
    if (!div_legal(DIV, CNT_W)) begin : g_bad_div
        $error("shift_reg_seq_ctrl: DIV must be 1..255 and fit in CNT_W bits");
    end

    seq_state_e        state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              dir_q, dir_d;
    logic [SCNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic              tick;
    logic              tick_clr;
    logic              shift_in_bit;
    logic              start_ready;

`ifdef SEQ_ROTATE_EN
    assign shift_in_bit = dir_q ? reg_q[0] : reg_q[WIDTH-1];
`else
    logic fill_q, fill_d;
    assign shift_in_bit = fill_q;
`endif

    // Divider restarts on every LOAD and on an abort so the next transfer begins aligned.
    assign tick_clr = (state_q == LOAD) || (abort && (state_q == SHIFT));

    shift_tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .clr   (tick_clr),
        .run   (state_q == SHIFT),
        .tick  (tick)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            data_q      <= '0;
            dir_q       <= 1'b0;
            shift_cnt_q <= '0;
`ifndef SEQ_ROTATE_EN
            fill_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            shift_cnt_q <= shift_cnt_d;
`ifndef SEQ_ROTATE_EN
            fill_q      <= fill_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dir_d       = dir_q;
        shift_cnt_d = shift_cnt_q;
`ifndef SEQ_ROTATE_EN
        fill_d      = fill_q;
`endif
        case (state_q)
            IDLE: begin
                if (req.start_valid) begin
                    data_d  = req.data_in;
                    dir_d   = req.dir_in;
`ifndef SEQ_ROTATE_EN
                    fill_d  = req.fill_in;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_cnt_d = '0;
                state_d     = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == SCNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
                // Abort beats completion: the final shift still happens but no done pulse.
                if (abort) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl_out    = CTRL_HOLD;
        enable_out  = 1'b0;
        s_in_out    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        start_ready = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
            end
            LOAD: begin
                ctrl_out   = CTRL_LOAD;
                enable_out = 1'b1;
                busy       = 1'b1;
            end
            SHIFT: begin
                ctrl_out   = dir_q ? CTRL_SHR : CTRL_SHL;
                enable_out = tick;
                s_in_out   = shift_in_bit;
                busy       = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
            end
        endcase
    end

    assign d_out           = data_q;
    assign req.start_ready = start_ready;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl: DIV=1 and DIV=3 instances, each driving a behavioural 8-bit register.
// Build option SEQ_ROTATE_EN switches the expected S_IN stream and final register value to rotation.
module tb_shift_reg_seq_ctrl;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLOCK = ~CLOCK;

    logic       sel  = 1'b0;
    logic       sv   = 1'b0;
    logic [7:0] din  = 8'h00;
    logic       dirv = 1'b0;
    logic       fill = 1'b0;
    logic       ab   = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    shift_reg_seq_ctrl_if #(.WIDTH(8)) if1 ();
    shift_reg_seq_ctrl_if #(.WIDTH(8)) if3 ();

    assign if1.start_valid = sv & ~sel;
    assign if3.start_valid = sv & sel;
    assign if1.data_in     = din;
    assign if3.data_in     = din;
    assign if1.dir_in      = dirv;
    assign if3.dir_in      = dirv;
    assign if1.fill_in     = fill;
    assign if3.fill_in     = fill;

    logic [1:0] ctrl1, ctrl3;
    logic       en1, en3, sin1, sin3, busy1, busy3, done1, done3;
    logic [7:0] d1, d3;
    logic [7:0] reg1 = 8'h00;
    logic [7:0] reg3 = 8'h00;

    shift_reg_seq_ctrl #(.WIDTH(8), .DIV(1), .CNT_W(8)) dut1 (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .req        (if1),
        .abort      (ab & ~sel),
`ifdef SEQ_ROTATE_EN
        .reg_q      (reg1),
`endif
        .ctrl_out   (ctrl1),
        .enable_out (en1),
        .s_in_out   (sin1),
        .d_out      (d1),
        .busy       (busy1),
        .done       (done1)
    );

    shift_reg_seq_ctrl #(.WIDTH(8), .DIV(3), .CNT_W(8)) dut3 (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .req        (if3),
        .abort      (ab & sel),
`ifdef SEQ_ROTATE_EN
        .reg_q      (reg3),
`endif
        .ctrl_out   (ctrl3),
        .enable_out (en3),
        .s_in_out   (sin3),
        .d_out      (d3),
        .busy       (busy3),
        .done       (done3)
    );

    // Universal shift register behaviour: 00 hold, 01 toward MSB, 10 load, 11 toward LSB.
    always @(posedge CLOCK) begin
        if (en1) begin
            case (ctrl1)
                2'b10:   reg1 <= d1;
                2'b01:   reg1 <= {reg1[6:0], sin1};
                2'b11:   reg1 <= {sin1, reg1[7:1]};
                default: reg1 <= reg1;
            endcase
        end
        if (en3) begin
            case (ctrl3)
                2'b10:   reg3 <= d3;
                2'b01:   reg3 <= {reg3[6:0], sin3};
                2'b11:   reg3 <= {sin3, reg3[7:1]};
                default: reg3 <= reg3;
            endcase
        end
    end

    wire [1:0] o_ctrl  = sel ? ctrl3 : ctrl1;
    wire       o_en    = sel ? en3 : en1;
    wire       o_sin   = sel ? sin3 : sin1;
    wire [7:0] o_d     = sel ? d3 : d1;
    wire       o_busy  = sel ? busy3 : busy1;
    wire       o_done  = sel ? done3 : done1;
    wire       o_ready = sel ? if3.start_ready : if1.start_ready;
    wire [7:0] o_reg   = sel ? reg3 : reg1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Expected register after n shifts of word w: fill bits enter, or the word rotates.
    function automatic logic [7:0] exp_reg(input logic [7:0] w, input bit d, input bit f, input int n);
`ifdef SEQ_ROTATE_EN
        int k = n % 8;
        logic [15:0] dbl = {w, w};
        if (d) return dbl[k +: 8];
        else   return dbl[(8 - k) +: 8];
`else
        logic [7:0] ones = 8'hFF;
        if (n >= 8) return f ? 8'hFF : 8'h00;
        if (d) return (w >> n) | (f ? ~(ones >> n) : 8'h00);
        else   return (w << n) | (f ? ~(ones << n) : 8'h00);
`endif
    endfunction

    task automatic chk_idle_after(input string tag);
        chk({tag, "_ctrl"}, o_ctrl, 2'b00);
        chk({tag, "_en"}, o_en, 1'b0);
        chk({tag, "_ready"}, o_ready, 1'b1);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_done"}, o_done, 1'b0);
    endtask

    // Runs one transfer from an IDLE cycle. abort_k: abort on the k-th enabled shift (-1 none);
    // reset_c: assert RESET in SHIFT cycle reset_c (-1 none); hold: keep valid high with nxt after LOAD.
    task automatic run_xfer(input bit s, input logic [7:0] w, input bit d, input bit f,
                            input int abort_k, input int reset_c, input bit hold, input logic [7:0] nxt);
        int  divv;
        int  nsh;
        bit  exp_en;
        bit  ebit;
        divv = s ? 3 : 1;
        sel  = s;
        din  = w;
        dirv = d;
        fill = f;
        sv   = 1'b1;
        chk("ready_idle", o_ready, 1'b1);
        step();
        if (hold) din = nxt;
        else sv = 1'b0;
        chk("load_ctrl", o_ctrl, 2'b10);
        chk("load_en", o_en, 1'b1);
        chk("load_d", o_d, w);
        chk("load_busy", o_busy, 1'b1);
        chk("load_ready", o_ready, 1'b0);
        nsh = 0;
        for (int c = 0; c < 8 * divv; c++) begin
            step();
            exp_en = ((c % divv) == (divv - 1));
            chk("shift_ctrl", o_ctrl, d ? 2'b11 : 2'b01);
            chk("shift_en", o_en, exp_en);
            chk("shift_busy", o_busy, 1'b1);
            chk("shift_d", o_d, w);
            chk("shift_done", o_done, 1'b0);
            chk("shift_ready", o_ready, 1'b0);
            if (exp_en) begin
                ebit = d ? w[nsh] : w[7 - nsh];
                chk("serial_end", d ? o_reg[0] : o_reg[7], ebit);
`ifdef SEQ_ROTATE_EN
                chk("s_in_rot", o_sin, ebit);
`else
                chk("s_in_fill", o_sin, f);
`endif
                nsh++;
                if (nsh == abort_k) begin
                    ab = 1'b1;
                    step();
                    ab = 1'b0;
                    chk_idle_after("abort");
                    chk("abort_reg", o_reg, exp_reg(w, d, f, nsh));
                    for (int i = 0; i < 3; i++) begin
                        step();
                        chk("abort_no_done", o_done, 1'b0);
                    end
                    return;
                end
            end
            if (c == reset_c) begin
                RESET = 1'b1;
                step();
                RESET = 1'b0;
                chk_idle_after("rst");
                chk("rst_sin", o_sin, 1'b0);
                chk("rst_d", o_d, 8'h00);
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("rst_no_done", o_done, 1'b0);
                    chk("rst_ready", o_ready, 1'b1);
                end
                return;
            end
        end
        step();
        chk("done_pulse", o_done, 1'b1);
        chk("done_ctrl", o_ctrl, 2'b00);
        chk("done_en", o_en, 1'b0);
        chk("done_busy", o_busy, 1'b0);
        chk("done_ready", o_ready, 1'b0);
        chk("final_reg", o_reg, exp_reg(w, d, f, 8));
        step();
        chk("ready_back", o_ready, 1'b1);
        chk("done_gone", o_done, 1'b0);
        chk("idle_d_hold", o_d, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("reset_ctrl", o_ctrl, 2'b00);
            chk("reset_en", o_en, 1'b0);
            chk("reset_sin", o_sin, 1'b0);
            chk("reset_d", o_d, 8'h00);
            chk("reset_busy", o_busy, 1'b0);
            chk("reset_done", o_done, 1'b0);
            chk("reset_ready", o_ready, 1'b1);
        end
        RESET = 1'b0;
        sel   = 1'b0;
        step();

        run_xfer(1'b0, 8'hA5, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00);
        run_xfer(1'b1, 8'h81, 1'b1, 1'b1, -1, -1, 1'b0, 8'h00);
        run_xfer(1'b0, 8'hF0, 1'b0, 1'b0, 4, -1, 1'b0, 8'h00);
        run_xfer(1'b1, 8'h5A, 1'b0, 1'b1, 8, -1, 1'b0, 8'h00);
        run_xfer(1'b0, 8'h77, 1'b1, 1'b0, -1, 2, 1'b0, 8'h00);
        run_xfer(1'b0, 8'h3C, 1'b0, 1'b1, -1, -1, 1'b1, 8'hC3);
        run_xfer(1'b0, 8'hC3, 1'b0, 1'b1, -1, -1, 1'b0, 8'h00);
        run_xfer(1'b1, 8'h96, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00);

        for (int t = 0; t < 24; t++) begin
            bit         rs, rd, rf;
            logic [7:0] rw;
            int         rk, gap;
            rs  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            rf  = 1'($urandom_range(0, 1));
            rw  = 8'($urandom_range(0, 255));
            rk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
            gap = int'($urandom_range(0, 2));
            sel = rs;
            for (int g = 0; g < gap; g++) begin
                step();
                chk("gap_ready", o_ready, 1'b1);
            end
            run_xfer(rs, rw, rd, rf, rk, -1, 1'b0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq_ctrl.md
Name: shift_reg_seq_ctrl

Overview:
- Upstream sequencer for the 8-bit universal shift register (CTRL codes: 00 hold, 01 shift MSB<LSB, 10 parallel load, 11 shift MSB>LSB).
- Accepts one word over a valid/ready handshake.
- Drives the register's CTRL, ENABLE, S_IN and D inputs to parallel-load the word, then shift it out fully in the chosen direction.
- Reports busy and a one-cycle done pulse; the register's serial end is the transmit line.

Parameters:
- WIDTH, 8: word width and number of shifts per transfer; must equal the register width.
- DIV, 1: clock cycles per shift step; legal range 1..255; DIV=1 shifts every cycle.
- CNT_W, 8: width of the divider counter; must satisfy DIV <= 2**CNT_W.

Ports:
- CLOCK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start_valid  input  1  request carries a word.
- start_ready  output  1  block can accept a request (IDLE only).
- data_in  input  WIDTH  word to transmit.
- dir_in  input  1  0 = shift MSB<LSB (CTRL 01), 1 = shift MSB>LSB (CTRL 11).
- fill_in  input  1  bit injected on S_IN during every shift.
- abort  input  1  cancel the transfer in progress.
- ctrl_out  output  2  to register CTRL.
- enable_out  output  1  to register ENABLE.
- s_in_out  output  1  to register S_IN.
- d_out  output  WIDTH  to register D.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle pulse after the final shift.

Behaviour:
- Moore outputs, decoded only from registered state and latched operands; no input-to-output combinational path.
- Reset values: state IDLE, ctrl_out=00, enable_out=0, s_in_out=0, d_out=0, busy=0, done=0, start_ready=1, all counters 0.
- IDLE:
  - Outputs: start_ready=1, ctrl_out=00, enable_out=0.
  - On start_valid & start_ready: latch data_in, dir_in and fill_in, then go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: ctrl_out=10, enable_out=1, d_out=latched word.
  - Clear the shift and divider counters, then go to SHIFT.
- SHIFT:
  - Outputs: ctrl_out = latched dir ? 11 : 01; s_in_out = latched fill.
  - Divider counts 0..DIV-1 and wraps. enable_out=1 only in the cycle where the divider equals DIV-1; the shift counter increments on that cycle.
  - When the shift counter reaches WIDTH, go to DONE; the WIDTH-th enabled cycle is the last SHIFT cycle.
- DONE (exactly 1 cycle):
  - Outputs: done=1, ctrl_out=00, enable_out=0. Go to IDLE.
- Latency: acceptance at edge k gives LOAD in cycle k+1, WIDTH*DIV SHIFT cycles, then DONE. start_ready is high again WIDTH*DIV+2 cycles after acceptance.
- d_out holds the latched word from LOAD onward; it changes only at the next acceptance.
- abort:
  - Sampled in LOAD or SHIFT; next state is IDLE with ctrl_out=00, enable_out=0 and no done pulse.
  - Abort on the final shift cycle wins: that shift still occurs (enable was already high), but there is no done pulse.
  - Ignored in IDLE and DONE.
- start_valid during busy is ignored; the requester must hold it until start_ready.
- RESET mid-transfer returns to IDLE immediately at the next edge, with reset values and no done pulse. The register contents are left to the register's own reset.

Optional Feature:
- Macro SEQ_ROTATE_EN.
- Defined:
  - Adds input reg_q[WIDTH-1:0] (the register's parallel output).
  - In SHIFT, s_in_out = dir ? reg_q[0] : reg_q[WIDTH-1], so the register rotates. After WIDTH shifts it holds the original word.
  - fill_in is ignored.
- Undefined: no reg_q port; s_in_out = latched fill bit.

Decomposition:
- Shared package:
  - state enum: IDLE, LOAD, SHIFT, DONE.
  - CTRL code constants: CTRL_HOLD=2'b00, CTRL_SHL=2'b01, CTRL_LOAD=2'b10, CTRL_SHR=2'b11.
  - DIV and WIDTH legality checks.
- One natural sub-module, shift_tick_gen: the DIV counter emitting a one-cycle tick. It has synchronous clear from LOAD, abort and RESET.

Test Plan:
- Reset, then data_in=8'hA5, dir=0, fill=0, DIV=1:
  - LOAD cycle with ctrl=10, d_out=A5, then 8 cycles of ctrl=01, enable=1, then done pulse.
  - Register model ends at 00; MSB stream 1,0,1,0,0,1,0,1.
- data_in=8'h81, dir=1, fill=1, DIV=3:
  - enable high on every 3rd SHIFT cycle, 8 pulses, 24 SHIFT cycles.
  - Register ends at FF; start_ready returns 26 cycles after acceptance.
- Assert abort after 4 shifts (DIV=1, 8'hF0, dir=0):
  - next cycle IDLE, ctrl=00, enable=0, no done; register model holds 00.
- RESET asserted in the 3rd SHIFT cycle:
  - next edge gives all reset values, start_ready=1, done never pulses.
- Back-to-back: start_valid held high with 8'h3C then 8'h C3:
  - second word is accepted only in the IDLE cycle after DONE, with no lost or duplicated LOAD.
- SEQ_ROTATE_EN, 8'h96, dir=1, reg_q from register model:
  - after 8 shifts the register equals 96; s_in stream 0,1,1,0,1,0,0,1.
